// File: rtl/cpu_defs_pkg.sv
// Shared integer-datapath definitions: MIPS opcode/funct encodings, the
// one-hot alu_op bit positions and width. Decode and the ALU both use these,
// so the bit positions here are the contract between the two stages.
package cpu_defs;

   localparam int unsigned ALU_OP_W = 12;

   localparam int unsigned ALU_ADD  = 0;
   localparam int unsigned ALU_SUB  = 1;
   localparam int unsigned ALU_SLT  = 2;
   localparam int unsigned ALU_SLTU = 3;
   localparam int unsigned ALU_SLL  = 4;
   localparam int unsigned ALU_SRL  = 5;
   localparam int unsigned ALU_SRA  = 6;
   localparam int unsigned ALU_LUI  = 7;
   localparam int unsigned ALU_AND  = 8;
   localparam int unsigned ALU_OR   = 9;
   localparam int unsigned ALU_XOR  = 10;
   localparam int unsigned ALU_NOR  = 11;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   function automatic logic [ALU_OP_W-1:0] op_bit(input int unsigned idx);
      return ALU_OP_W'(1) << idx;
   endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of MIPS ALU-class instructions into a one-hot alu_op
// plus both operands and destination.
// Ports:
//   inst    - instruction word held in decode
//   rs_data - register file data for rs
//   rt_data - register file data for rt
//   alu_op  - one-hot operation, all-zero only for unsupported encodings
//   src1/2  - ALU operands
//   dest    - destination register (0 = no writeback)
//   illegal - encoding not in the supported set
module alu_op_decoder
   import cpu_defs::*;
(
   input  logic [31:0]         inst,
   input  logic [31:0]         rs_data,
   input  logic [31:0]         rt_data,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [31:0]         src1,
   output logic [31:0]         src2,
   output logic [4:0]          dest,
   output logic                illegal
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  sa;
   logic [15:0] imm;
   logic        unused_rs_field;

   assign opcode = inst[31:26];
   assign rt     = inst[20:16];
   assign rd     = inst[15:11];
   assign sa     = inst[10:6];
   assign funct  = inst[5:0];
   assign imm    = inst[15:0];
   // rs only selects the read port, which the parent drives directly.
   assign unused_rs_field = ^inst[25:21];

   always_comb begin
      alu_op  = '0;
      src1    = rs_data;
      src2    = rt_data;
      dest    = '0;
      illegal = 1'b0;
      if (opcode == OP_SPECIAL) begin
         dest = rd;
         case (funct)
            FN_ADDU: alu_op = op_bit(ALU_ADD);
            FN_SUBU: alu_op = op_bit(ALU_SUB);
            FN_SLT:  alu_op = op_bit(ALU_SLT);
            FN_SLTU: alu_op = op_bit(ALU_SLTU);
            FN_AND:  alu_op = op_bit(ALU_AND);
            FN_OR:   alu_op = op_bit(ALU_OR);
            FN_XOR:  alu_op = op_bit(ALU_XOR);
            FN_NOR:  alu_op = op_bit(ALU_NOR);
            FN_SLL, FN_SRL, FN_SRA: begin
               alu_op = (funct == FN_SLL) ? op_bit(ALU_SLL) :
                        (funct == FN_SRL) ? op_bit(ALU_SRL) : op_bit(ALU_SRA);
               src1   = rt_data;
               src2   = {27'b0, sa};
            end
            FN_SLLV, FN_SRLV, FN_SRAV: begin
               alu_op = (funct == FN_SLLV) ? op_bit(ALU_SLL) :
                        (funct == FN_SRLV) ? op_bit(ALU_SRL) : op_bit(ALU_SRA);
               src1   = rt_data;
               src2   = rs_data;
            end
            default: alu_op = '0;
         endcase
      end else begin
         dest = rt;
         case (opcode)
            OP_ADDIU: begin alu_op = op_bit(ALU_ADD);  src2 = {{16{imm[15]}}, imm}; end
            OP_SLTI:  begin alu_op = op_bit(ALU_SLT);  src2 = {{16{imm[15]}}, imm}; end
            OP_SLTIU: begin alu_op = op_bit(ALU_SLTU); src2 = {{16{imm[15]}}, imm}; end
            OP_ANDI:  begin alu_op = op_bit(ALU_AND);  src2 = {16'b0, imm}; end
            OP_ORI:   begin alu_op = op_bit(ALU_OR);   src2 = {16'b0, imm}; end
            OP_XORI:  begin alu_op = op_bit(ALU_XOR);  src2 = {16'b0, imm}; end
            OP_LUI: begin
               alu_op = op_bit(ALU_LUI);
               src1   = {16'b0, imm};
               src2   = '0;
            end
            default: alu_op = '0;
         endcase
      end
      // Every supported encoding sets exactly one bit, so an empty alu_op
      // is the single marker for "unsupported"; squash the payload there.
      if (alu_op == '0) begin
         illegal = 1'b1;
         src1    = '0;
         src2    = '0;
         dest    = '0;
      end
   end

endmodule

// File: rtl/id_alu_issue.sv
// Decode/issue stage: holds one instruction from fetch, decodes it and
// presents the one-hot ALU operation and operands toward execute with
// valid/allowin flow control, stall and flush.
// Ports:
//   clk, resetn              - clock, synchronous active-low reset
//   fs_to_ds_valid/inst/pc   - instruction offered by fetch
//   ds_allowin               - decode can take an instruction this cycle
//   ds_stall, flush          - hazard hold / discard of the held instruction
//   rf_raddr1/2, rf_rdata1/2 - register file read port (rs, rt)
//   ds_to_es_*, es_allowin   - issue interface toward execute
module id_alu_issue
   import cpu_defs::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic                fs_to_ds_valid,
   input  logic [31:0]         fs_to_ds_inst,
   input  logic [31:0]         fs_to_ds_pc,
   output logic                ds_allowin,
   input  logic                ds_stall,
   input  logic                flush,
   output logic [4:0]          rf_raddr1,
   output logic [4:0]          rf_raddr2,
   input  logic [31:0]         rf_rdata1,
   input  logic [31:0]         rf_rdata2,
   output logic                ds_to_es_valid,
   input  logic                es_allowin,
   output logic [ALU_OP_W-1:0] ds_to_es_alu_op,
   output logic [31:0]         ds_to_es_src1,
   output logic [31:0]         ds_to_es_src2,
   output logic [4:0]          ds_to_es_dest,
   output logic [31:0]         ds_to_es_pc,
   output logic                ds_to_es_illegal
);

   logic        ds_valid;
   logic [31:0] ds_inst;
   logic [31:0] ds_pc;
   logic        ds_ready_go;
   logic        ds_load;

   assign ds_ready_go    = ~ds_stall;
   assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
   assign ds_to_es_valid = ds_valid & ds_ready_go & ~flush;
   // Flush wins over a same-cycle fetch transfer.
   assign ds_load        = fs_to_ds_valid & ds_allowin & ~flush;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ds_valid <= 1'b0;
         ds_inst  <= '0;
         ds_pc    <= '0;
      end else begin
         if (flush)
            ds_valid <= 1'b0;
         else if (ds_allowin)
            ds_valid <= fs_to_ds_valid;
         if (ds_load) begin
            ds_inst <= fs_to_ds_inst;
            ds_pc   <= fs_to_ds_pc;
         end
      end
   end

   assign rf_raddr1   = ds_inst[25:21];
   assign rf_raddr2   = ds_inst[20:16];
   assign ds_to_es_pc = ds_pc;

   alu_op_decoder u_dec (
      .inst    (ds_inst),
      .rs_data (rf_rdata1),
      .rt_data (rf_rdata2),
      .alu_op  (ds_to_es_alu_op),
      .src1    (ds_to_es_src1),
      .src2    (ds_to_es_src2),
      .dest    (ds_to_es_dest),
      .illegal (ds_to_es_illegal)
   );

endmodule

// File: tb/tb_id_alu_issue.sv
module tb_id_alu_issue;

   logic        clk = 1'b0;
   logic        resetn;
   logic        fs_to_ds_valid;
   logic [31:0] fs_to_ds_inst;
   logic [31:0] fs_to_ds_pc;
   logic        ds_allowin;
   logic        ds_stall;
   logic        flush;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        ds_to_es_valid;
   logic        es_allowin;
   logic [11:0] ds_to_es_alu_op;
   logic [31:0] ds_to_es_src1, ds_to_es_src2, ds_to_es_pc;
   logic [4:0]  ds_to_es_dest;
   logic        ds_to_es_illegal;

   logic [31:0] regs [32];
   int n_cmp = 0;
   int n_err = 0;

   // spec-level model of the decode register
   logic        m_valid;
   logic [31:0] m_inst, m_pc;

   typedef struct packed {
      logic [11:0] op;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [4:0]  dest;
      logic        ill;
   } exp_t;

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   always #5 clk = ~clk;

   id_alu_issue dut (
      .clk(clk), .resetn(resetn),
      .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_inst(fs_to_ds_inst), .fs_to_ds_pc(fs_to_ds_pc),
      .ds_allowin(ds_allowin), .ds_stall(ds_stall), .flush(flush),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
      .ds_to_es_alu_op(ds_to_es_alu_op), .ds_to_es_src1(ds_to_es_src1), .ds_to_es_src2(ds_to_es_src2),
      .ds_to_es_dest(ds_to_es_dest), .ds_to_es_pc(ds_to_es_pc), .ds_to_es_illegal(ds_to_es_illegal)
   );

   // Mnemonic-level decode: operation index plus operand kind.
   // kinds: 0 rs/rt, 1 rt/sa, 2 rt/rs, 3 rs/sext, 4 rs/zext, 5 lui
   function automatic exp_t model(input logic [31:0] w, input logic [31:0] rs_v, input logic [31:0] rt_v);
      exp_t e;
      int idx = -1;
      int kind = 0;
      logic [5:0] opc = w[31:26];
      logic [5:0] fn = w[5:0];
      e = '0;
      if (opc == 6'h00) begin
         case (fn)
            6'h21: idx = 0;   6'h23: idx = 1;   6'h2A: idx = 2;   6'h2B: idx = 3;
            6'h24: idx = 8;   6'h25: idx = 9;   6'h26: idx = 10;  6'h27: idx = 11;
            6'h00: begin idx = 4; kind = 1; end
            6'h02: begin idx = 5; kind = 1; end
            6'h03: begin idx = 6; kind = 1; end
            6'h04: begin idx = 4; kind = 2; end
            6'h06: begin idx = 5; kind = 2; end
            6'h07: begin idx = 6; kind = 2; end
            default: idx = -1;
         endcase
      end else begin
         case (opc)
            6'h09: begin idx = 0;  kind = 3; end
            6'h0A: begin idx = 2;  kind = 3; end
            6'h0B: begin idx = 3;  kind = 3; end
            6'h0C: begin idx = 8;  kind = 4; end
            6'h0D: begin idx = 9;  kind = 4; end
            6'h0E: begin idx = 10; kind = 4; end
            6'h0F: begin idx = 7;  kind = 5; end
            default: idx = -1;
         endcase
      end
      if (idx < 0) begin
         e.ill = 1'b1;
         return e;
      end
      e.op = 12'd1 << idx;
      e.dest = (opc == 6'h00) ? w[15:11] : w[20:16];
      case (kind)
         0: begin e.s1 = rs_v; e.s2 = rt_v; end
         1: begin e.s1 = rt_v; e.s2 = 32'(w[10:6]); end
         2: begin e.s1 = rt_v; e.s2 = rs_v; end
         3: begin e.s1 = rs_v; e.s2 = 32'($signed(w[15:0])); end
         4: begin e.s1 = rs_v; e.s2 = {16'h0, w[15:0]}; end
         default: begin e.s1 = {16'h0, w[15:0]}; e.s2 = 32'h0; end
      endcase
      return e;
   endfunction

   // One clock edge: advance the model with the inputs present at the edge.
   task automatic tick();
      logic allow;
      @(posedge clk);
      allow = !m_valid || (!ds_stall && es_allowin);
      if (!resetn) begin
         m_valid = 1'b0; m_inst = '0; m_pc = '0;
      end else if (flush) begin
         m_valid = 1'b0;
      end else if (allow) begin
         m_valid = fs_to_ds_valid;
         if (fs_to_ds_valid) begin m_inst = fs_to_ds_inst; m_pc = fs_to_ds_pc; end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      fs_to_ds_valid = 0; fs_to_ds_inst = '0; fs_to_ds_pc = '0;
      ds_stall = 0; flush = 0; es_allowin = 1;
   endtask

   task automatic test_reset();
      resetn = 0; idle_inputs();
      tick(); tick();
      resetn = 1;
      #1;
      n_cmp++; if (ds_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin: got %b want 1", ds_allowin); end
      n_cmp++; if (ds_to_es_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ds_to_es_valid); end
      n_cmp++; if (ds_to_es_alu_op !== 12'h010) begin n_err++; $display("FAIL reset_alu_op: got %h want 010", ds_to_es_alu_op); end
      n_cmp++; if ({ds_to_es_src2, ds_to_es_dest, ds_to_es_pc, ds_to_es_illegal} !== '0) begin n_err++; $display("FAIL reset_bus: src2 %h dest %0d pc %h ill %b want zeros", ds_to_es_src2, ds_to_es_dest, ds_to_es_pc, ds_to_es_illegal); end
   endtask

   task automatic test_addiu();
      regs[1] = 32'd5;
      fs_to_ds_valid = 1; fs_to_ds_inst = 32'h2423FFFF; fs_to_ds_pc = 32'h100;
      tick();
      fs_to_ds_valid = 0;
      #1;
      n_cmp++; if (ds_to_es_valid !== 1'b1) begin n_err++; $display("FAIL addiu_valid: got %b want 1", ds_to_es_valid); end
      n_cmp++; if (ds_to_es_alu_op !== 12'h001) begin n_err++; $display("FAIL addiu_op: got %h want 001", ds_to_es_alu_op); end
      n_cmp++; if ({ds_to_es_src1, ds_to_es_src2} !== {32'd5, 32'hFFFFFFFF}) begin n_err++; $display("FAIL addiu_src: got %h %h want 5 ffffffff", ds_to_es_src1, ds_to_es_src2); end
      n_cmp++; if ({ds_to_es_dest, ds_to_es_pc} !== {5'd3, 32'h100}) begin n_err++; $display("FAIL addiu_dest_pc: got %0d %h want 3 100", ds_to_es_dest, ds_to_es_pc); end
      tick();
   endtask

   task automatic test_back_to_back();
      regs[2] = 32'h12340000;
      fs_to_ds_valid = 1; fs_to_ds_inst = 32'h3C021234; fs_to_ds_pc = 32'h200;
      tick();
      fs_to_ds_inst = 32'h34425678; fs_to_ds_pc = 32'h204;
      #1;
      n_cmp++; if ({ds_to_es_valid, ds_allowin, ds_to_es_alu_op} !== {2'b11, 12'h080}) begin n_err++; $display("FAIL b2b_lui: valid %b allowin %b op %h want 1 1 080", ds_to_es_valid, ds_allowin, ds_to_es_alu_op); end
      n_cmp++; if ({ds_to_es_src1, ds_to_es_src2, ds_to_es_dest} !== {32'h1234, 32'h0, 5'd2}) begin n_err++; $display("FAIL b2b_lui_src: got %h %h %0d want 1234 0 2", ds_to_es_src1, ds_to_es_src2, ds_to_es_dest); end
      tick();
      fs_to_ds_valid = 0;
      #1;
      n_cmp++; if ({ds_to_es_valid, ds_to_es_alu_op, ds_to_es_pc} !== {1'b1, 12'h200, 32'h204}) begin n_err++; $display("FAIL b2b_ori: valid %b op %h pc %h want 1 200 204", ds_to_es_valid, ds_to_es_alu_op, ds_to_es_pc); end
      n_cmp++; if ({ds_to_es_src1, ds_to_es_src2} !== {32'h12340000, 32'h5678}) begin n_err++; $display("FAIL b2b_ori_src: got %h %h want 12340000 5678", ds_to_es_src1, ds_to_es_src2); end
      tick();
   endtask

   task automatic test_sra();
      regs[5] = 32'h80000000;
      fs_to_ds_valid = 1; fs_to_ds_inst = 32'h000527C3; fs_to_ds_pc = 32'h300;
      tick();
      fs_to_ds_valid = 0;
      #1;
      n_cmp++; if ({ds_to_es_alu_op, ds_to_es_dest} !== {12'h040, 5'd4}) begin n_err++; $display("FAIL sra_op: got %h %0d want 040 4", ds_to_es_alu_op, ds_to_es_dest); end
      n_cmp++; if ({ds_to_es_src1, ds_to_es_src2} !== {32'h80000000, 32'h1F}) begin n_err++; $display("FAIL sra_src: got %h %h want 80000000 1f", ds_to_es_src1, ds_to_es_src2); end
      tick();
   endtask

   task automatic test_backpressure();
      regs[1] = 32'd10; regs[2] = 32'd3;
      fs_to_ds_valid = 1; fs_to_ds_inst = 32'h00223023; fs_to_ds_pc = 32'h400;
      es_allowin = 0;
      tick();
      fs_to_ds_inst = 32'h382700F0; fs_to_ds_pc = 32'h404;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if ({ds_to_es_valid, ds_allowin, ds_to_es_alu_op, ds_to_es_pc} !== {2'b10, 12'h002, 32'h400}) begin n_err++; $display("FAIL hold_ctl[%0d]: valid %b allowin %b op %h pc %h", i, ds_to_es_valid, ds_allowin, ds_to_es_alu_op, ds_to_es_pc); end
         n_cmp++; if ({ds_to_es_src1, ds_to_es_src2, ds_to_es_dest} !== {32'd10, 32'd3, 5'd6}) begin n_err++; $display("FAIL hold_data[%0d]: got %h %h %0d want a 3 6", i, ds_to_es_src1, ds_to_es_src2, ds_to_es_dest); end
         tick();
      end
      es_allowin = 1;
      #1;
      n_cmp++; if ({ds_to_es_valid, ds_allowin} !== 2'b11) begin n_err++; $display("FAIL hold_release: valid %b allowin %b want 1 1", ds_to_es_valid, ds_allowin); end
      tick();
      fs_to_ds_valid = 0;
      #1;
      n_cmp++; if ({ds_to_es_valid, ds_to_es_alu_op, ds_to_es_src2, ds_to_es_dest} !== {1'b1, 12'h400, 32'hF0, 5'd7}) begin n_err++; $display("FAIL hold_next: valid %b op %h src2 %h dest %0d want 1 400 f0 7", ds_to_es_valid, ds_to_es_alu_op, ds_to_es_src2, ds_to_es_dest); end
      tick();
   endtask

   task automatic test_stall();
      regs[1] = 32'd1; regs[2] = 32'd2;
      fs_to_ds_valid = 1; fs_to_ds_inst = 32'h00224021; fs_to_ds_pc = 32'h500;
      tick();
      fs_to_ds_valid = 1; fs_to_ds_inst = 32'h2423FFFF; ds_stall = 1;
      #1;
      n_cmp++; if ({ds_to_es_valid, ds_allowin, ds_to_es_src1} !== {2'b00, 32'd1}) begin n_err++; $display("FAIL stall_a: valid %b allowin %b src1 %h want 0 0 1", ds_to_es_valid, ds_allowin, ds_to_es_src1); end
      regs[1] = 32'd7;
      #1;
      n_cmp++; if (ds_to_es_src1 !== 32'd7) begin n_err++; $display("FAIL stall_track: got %h want 7", ds_to_es_src1); end
      tick();
      #1;
      n_cmp++; if ({ds_to_es_valid, ds_to_es_src1, ds_to_es_pc} !== {1'b0, 32'd7, 32'h500}) begin n_err++; $display("FAIL stall_b: valid %b src1 %h pc %h want 0 7 500", ds_to_es_valid, ds_to_es_src1, ds_to_es_pc); end
      fs_to_ds_valid = 0; ds_stall = 0;
      #1;
      n_cmp++; if ({ds_to_es_valid, ds_to_es_alu_op, ds_to_es_src1} !== {1'b1, 12'h001, 32'd7}) begin n_err++; $display("FAIL stall_release: valid %b op %h src1 %h want 1 001 7", ds_to_es_valid, ds_to_es_alu_op, ds_to_es_src1); end
      tick();
   endtask

   task automatic test_illegal_flush();
      fs_to_ds_valid = 1; fs_to_ds_inst = 32'hFC221234; fs_to_ds_pc = 32'h600;
      tick();
      fs_to_ds_inst = 32'h2423FFFF; fs_to_ds_pc = 32'h604;
      #1;
      n_cmp++; if ({ds_to_es_illegal, ds_to_es_alu_op, ds_to_es_dest} !== {1'b1, 12'h0, 5'd0}) begin n_err++; $display("FAIL illegal: ill %b op %h dest %0d want 1 000 0", ds_to_es_illegal, ds_to_es_alu_op, ds_to_es_dest); end
      n_cmp++; if ({ds_to_es_src1, ds_to_es_src2} !== 64'h0) begin n_err++; $display("FAIL illegal_src: got %h %h want 0 0", ds_to_es_src1, ds_to_es_src2); end
      flush = 1;
      #1;
      n_cmp++; if (ds_to_es_valid !== 1'b0) begin n_err++; $display("FAIL flush_mask: got %b want 0", ds_to_es_valid); end
      tick();
      flush = 0; fs_to_ds_valid = 0;
      #1;
      n_cmp++; if ({ds_to_es_valid, ds_allowin, ds_to_es_pc, ds_to_es_illegal} !== {2'b01, 32'h600, 1'b1}) begin n_err++; $display("FAIL flush_drop: valid %b allowin %b pc %h ill %b want 0 1 600 1", ds_to_es_valid, ds_allowin, ds_to_es_pc, ds_to_es_illegal); end
      tick();
   endtask

   task automatic test_mid_reset();
      fs_to_ds_valid = 1; fs_to_ds_inst = 32'h3C02ABCD; fs_to_ds_pc = 32'h700;
      tick();
      resetn = 0; flush = 1; ds_stall = 1; es_allowin = 0;
      tick();
      resetn = 1; idle_inputs();
      #1;
      n_cmp++; if ({ds_to_es_valid, ds_allowin, ds_to_es_alu_op} !== {2'b01, 12'h010}) begin n_err++; $display("FAIL mreset_ctl: valid %b allowin %b op %h want 0 1 010", ds_to_es_valid, ds_allowin, ds_to_es_alu_op); end
      n_cmp++; if ({ds_to_es_src1, ds_to_es_src2, ds_to_es_dest, ds_to_es_pc, ds_to_es_illegal} !== {regs[0], 32'h0, 5'd0, 32'h0, 1'b0}) begin n_err++; $display("FAIL mreset_bus: %h %h %0d %h %b want 0s", ds_to_es_src1, ds_to_es_src2, ds_to_es_dest, ds_to_es_pc, ds_to_es_illegal); end
   endtask

   function automatic logic [31:0] rand_inst();
      logic [5:0] fns [14] = '{6'h21, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26,
                               6'h27, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
      int k = $urandom_range(0, 21);
      logic [31:0] w = $urandom();
      if (k < 14)      w = {6'h00, w[25:6], fns[k]};
      else if (k < 21) w = {6'(k - 14 + 9), w[25:0]};
      return w;
   endfunction

   task automatic test_random();
      exp_t e;
      logic ev, ea;
      for (int i = 1; i < 32; i++) regs[i] = $urandom();
      for (int c = 0; c < 400; c++) begin
         fs_to_ds_valid = ($urandom_range(0, 3) != 0);
         fs_to_ds_inst  = rand_inst();
         fs_to_ds_pc    = $urandom();
         ds_stall       = ($urandom_range(0, 3) == 0);
         flush          = ($urandom_range(0, 9) == 0);
         es_allowin     = ($urandom_range(0, 3) != 0);
         regs[$urandom_range(1, 31)] = $urandom();
         #1;
         e  = model(m_inst, regs[m_inst[25:21]], regs[m_inst[20:16]]);
         ev = m_valid && !ds_stall && !flush;
         ea = !m_valid || (!ds_stall && es_allowin);
         n_cmp++; if ({ds_to_es_valid, ds_allowin} !== {ev, ea}) begin n_err++; $display("FAIL rnd_flow[%0d]: got %b%b want %b%b", c, ds_to_es_valid, ds_allowin, ev, ea); end
         n_cmp++; if ({rf_raddr1, rf_raddr2, ds_to_es_pc} !== {m_inst[25:21], m_inst[20:16], m_pc}) begin n_err++; $display("FAIL rnd_addr_pc[%0d]: got %0d %0d %h want %0d %0d %h", c, rf_raddr1, rf_raddr2, ds_to_es_pc, m_inst[25:21], m_inst[20:16], m_pc); end
         n_cmp++; if ({ds_to_es_alu_op, ds_to_es_src1, ds_to_es_src2, ds_to_es_dest, ds_to_es_illegal} !== e) begin n_err++; $display("FAIL rnd_decode[%0d] inst %h: got op %h s1 %h s2 %h d %0d i %b want op %h s1 %h s2 %h d %0d i %b", c, m_inst, ds_to_es_alu_op, ds_to_es_src1, ds_to_es_src2, ds_to_es_dest, ds_to_es_illegal, e.op, e.s1, e.s2, e.dest, e.ill); end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      m_valid = 0; m_inst = '0; m_pc = '0;
      resetn = 0; idle_inputs();
      @(negedge clk);
      test_reset();
      test_addiu();
      test_back_to_back();
      test_sra();
      test_backpressure();
      test_stall();
      test_illegal_flush();
      test_random();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
